// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock/tick generator.
//   MAX_NCHAN : largest supported channel count (the write channel field is CHAN_W bits)
//   CHAN_W    : width of the write-port channel select
//   DIV_*     : divisors for the standard rates from a 100 MHz system clock
package clkdiv_pkg;
  localparam int MAX_NCHAN = 8;
  localparam int CHAN_W    = 3;

  localparam logic [25:0] DIV_25MHZ = 26'd2;
  localparam logic [25:0] DIV_1HZ   = 26'd50_000_000;
  localparam logic [25:0] DIV_80HZ  = 26'd625_000;
endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active and shadow divisor, pending flag,
// registered tick strobe and toggled divided clock.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_en         : channel run enable
//   i_sync       : phase realign (clears counter and divided clock)
//   i_wr         : accepted write strobe (already qualified by the top)
//   i_wr_div     : divisor carried by the write
//   o_pending    : shadow holds a divisor not yet applied
//   o_tick       : 1-cycle strobe per divisor period
//   o_clk        : divided clock, toggles on every tick
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int               DIV_W   = 26,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(2)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_pending,
  output logic             o_tick,
  output logic             o_clk
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_tick;
  logic             r_clk;

  logic [DIV_W-1:0] w_last;
  logic             w_wrap;
  logic             w_boundary;

  // Divisor 0 behaves as divisor 1: the last count is 0 either way.
  assign w_last     = (r_active == '0) ? '0 : r_active - 1'b1;
  assign w_wrap     = (r_cnt == w_last);
  // Any point where the counter restarts from zero is a safe place to swap
  // the divisor without creating a short o_clk phase.
  assign w_boundary = i_sync | ~i_en | w_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_active  <= DEF_DIV;
      r_shadow  <= DEF_DIV;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_clk     <= 1'b0;
    end else begin
      if (i_sync) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (!i_en) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_clk  <= ~r_clk;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end

      if (r_pending && w_boundary) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end

      // A write is only offered while nothing is pending, so it never
      // collides with the apply above; it waits for the next boundary.
      if (i_wr && !r_pending) begin
        r_shadow  <= i_wr_div;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_tick    = r_tick;
  assign o_clk     = r_clk;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel runtime-programmable clock/tick generator.
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   i_en         : per-channel run enable
//   i_sync       : 1-cycle pulse, phase-realigns all channels
//   i_wr_valid   : divisor write request
//   i_wr_chan    : write target channel (values >= NCHAN are dropped)
//   i_wr_div     : new divisor
//   o_wr_ready   : write accepted when valid & ready at posedge
//   o_pending    : per-channel written-but-not-applied flag
//   o_tick       : per-channel 1-cycle strobe
//   o_clk        : per-channel divided clock (period 2*div)
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int                     NCHAN    = 3,
  parameter int                     DIV_W    = 26,
  parameter logic [NCHAN*DIV_W-1:0] DEF_DIVS = {DIV_80HZ, DIV_1HZ, DIV_25MHZ}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCHAN-1:0]  i_en,
  input  logic              i_sync,
  input  logic              i_wr_valid,
  input  logic [CHAN_W-1:0] i_wr_chan,
  input  logic [DIV_W-1:0]  i_wr_div,
  output logic              o_wr_ready,
  output logic [NCHAN-1:0]  o_pending,
  output logic [NCHAN-1:0]  o_tick,
  output logic [NCHAN-1:0]  o_clk
);

  logic [NCHAN-1:0]     w_pending;
  logic [MAX_NCHAN-1:0] w_pend_ext;

  // Unused channel slots read as "not pending", so writes to them are
  // always ready and simply fall on the floor.
  always_comb begin
    w_pend_ext              = '0;
    w_pend_ext[NCHAN-1:0]   = w_pending;
  end

  assign o_wr_ready = ~w_pend_ext[i_wr_chan];
  assign o_pending  = w_pending;

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic w_wr;
      assign w_wr = i_wr_valid && (i_wr_chan == CHAN_W'(gi)) && !w_pending[gi];

      clkdiv_chan #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIVS[gi*DIV_W +: DIV_W])
      ) u_chan (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en[gi]),
        .i_sync    (i_sync),
        .i_wr      (w_wr),
        .i_wr_div  (i_wr_div),
        .o_pending (w_pending[gi]),
        .o_tick    (o_tick[gi]),
        .o_clk     (o_clk[gi])
      );
    end
  endgenerate

endmodule
